// File: rtl/nmos_sr_bank_pkg.sv
// Shared constants for the two-phase SR flip-flop bank: S&R resolution modes
// and the phase-tracking FSM state type.
package nmos_sr_pkg;

    localparam int SR_RST_DOM = 0;
    localparam int SR_SET_DOM = 1;
    localparam int SR_TOGGLE  = 2;

    typedef enum logic {
        PH_IDLE  = 1'b0,
        PH_ARMED = 1'b1
    } phase_e;

endpackage

// File: rtl/nmos_sr_bank_if.sv
// Bundle of phase enables, per-channel S/R inputs and the bank's status outputs.
// The master side drives c1/c2/s/r; the slave side (the bank) drives the rest.
interface nmos_sr_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             c1;
    logic             c2;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic             phase_err;
    logic [CNT_W-1:0] cyc_cnt;
    logic             ovl_err;

    modport master (
        output c1, c2, s, r,
        input  q, phase_err, cyc_cnt, ovl_err
    );

    modport slave (
        input  c1, c2, s, r,
        output q, phase_err, cyc_cnt, ovl_err
    );
endinterface

// File: rtl/nmos_sr_bank_nx.sv
// Per-bit SR next-state function. MODE picks what happens when S and R are
// both asserted: reset wins, set wins, or the bit toggles.
module nmos_sr_nx
    import nmos_sr_pkg::*;
#(
    parameter int MODE = SR_RST_DOM
) (
    input  logic q_i,
    input  logic s_i,
    input  logic r_i,
    output logic nx_o
);

    always_comb begin
        nx_o = (q_i | s_i) & ~r_i;
        if (MODE == SR_SET_DOM) begin
            nx_o = s_i | (q_i & ~r_i);
        end else if (MODE == SR_TOGGLE) begin
            nx_o = (s_i & r_i) ? ~q_i : ((q_i | s_i) & ~r_i);
        end
    end

endmodule

// File: rtl/nmos_sr_bank.sv
// Two-phase (PHI2 sample / PHI1 transfer) SR flip-flop bank on a single fast clock.
// Define NMOS_SR_BANK_OVL_CHK_EN to enable the sticky c1&c2 overlap flag.
module nmos_sr_bank
    import nmos_sr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               MODE         = SR_RST_DOM,
    parameter logic [WIDTH-1:0] INIT         = '0,
    parameter int               STRICT_PHASE = 1,
    parameter int               CNT_W        = 16
) (
    input  logic         main_clk,
    input  logic         main_rst,
    nmos_sr_bank_if.slave bus
);

    logic [WIDTH-1:0] stage2_q, stage2_d;
    logic [WIDTH-1:0] q_q, q_d;
    phase_e           state_q, state_d;
    logic             phase_err_q, phase_err_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [WIDTH-1:0] nx_w;
    logic             armed_w;
    logic             xfer_ok_w;

    // Next-state is computed from the registered output, never from stage2.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_nx
        nmos_sr_nx #(.MODE(MODE)) u_nx (
            .q_i  (q_q[gi]),
            .s_i  (bus.s[gi]),
            .r_i  (bus.r[gi]),
            .nx_o (nx_w[gi])
        );
    end

    assign armed_w   = (state_q == PH_ARMED);
    assign xfer_ok_w = (STRICT_PHASE != 0) ? armed_w : 1'b1;

    always_comb begin
        stage2_d    = stage2_q;
        q_d         = q_q;
        state_d     = state_q;
        phase_err_d = 1'b0;
        cyc_cnt_d   = cyc_cnt_q;

        if (bus.c2) begin
            stage2_d = nx_w;
        end
        // On overlap both stages read pre-edge values, so q gets the old sample.
        if (bus.c1 && xfer_ok_w) begin
            q_d = stage2_q;
        end
        if (bus.c1 && armed_w) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
        if (bus.c1 && !armed_w && (STRICT_PHASE != 0)) begin
            phase_err_d = 1'b1;
        end

        if (bus.c2) begin
            state_d = PH_ARMED;
        end else if (bus.c1) begin
            state_d = PH_IDLE;
        end
    end

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            stage2_q    <= INIT;
            q_q         <= INIT;
            state_q     <= PH_IDLE;
            phase_err_q <= 1'b0;
            cyc_cnt_q   <= '0;
        end else begin
            stage2_q    <= stage2_d;
            q_q         <= q_d;
            state_q     <= state_d;
            phase_err_q <= phase_err_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

`ifdef NMOS_SR_BANK_OVL_CHK_EN
    logic ovl_q;

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            ovl_q <= 1'b0;
        end else if (bus.c1 && bus.c2) begin
            ovl_q <= 1'b1;
        end
    end

    assign bus.ovl_err = ovl_q;
`else
    assign bus.ovl_err = 1'b0;
`endif

    assign bus.q         = q_q;
    assign bus.phase_err = phase_err_q;
    assign bus.cyc_cnt   = cyc_cnt_q;

endmodule

// File: tb/tb_nmos_sr_bank.sv
// Directed bench for nmos_sr_bank: four instances (reset-dominant, set-dominant,
// toggle, legacy phase) driven by one shared stimulus sequence.
module tb_nmos_sr_bank;
    import nmos_sr_pkg::*;

    localparam int         WIDTH = 8;
    localparam int         CNT_W = 4;
    localparam logic [7:0] INIT  = 8'hA5;
`ifdef NMOS_SR_BANK_OVL_CHK_EN
    localparam logic EXP_OVL = 1'b1;
`else
    localparam logic EXP_OVL = 1'b0;
`endif

    logic main_clk = 1'b0;
    logic main_rst = 1'b1;
    int   n_tests  = 0;
    int   n_fail   = 0;

    always #5 main_clk = ~main_clk;

    nmos_sr_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if0 ();
    nmos_sr_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if1 ();
    nmos_sr_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if2 ();
    nmos_sr_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if3 ();

    nmos_sr_bank #(.WIDTH(WIDTH), .MODE(SR_RST_DOM), .INIT(INIT), .STRICT_PHASE(1), .CNT_W(CNT_W))
        u_dut0 (.main_clk(main_clk), .main_rst(main_rst), .bus(if0.slave));
    nmos_sr_bank #(.WIDTH(WIDTH), .MODE(SR_SET_DOM), .INIT(INIT), .STRICT_PHASE(1), .CNT_W(CNT_W))
        u_dut1 (.main_clk(main_clk), .main_rst(main_rst), .bus(if1.slave));
    nmos_sr_bank #(.WIDTH(WIDTH), .MODE(SR_TOGGLE), .INIT(INIT), .STRICT_PHASE(1), .CNT_W(CNT_W))
        u_dut2 (.main_clk(main_clk), .main_rst(main_rst), .bus(if2.slave));
    nmos_sr_bank #(.WIDTH(WIDTH), .MODE(SR_RST_DOM), .INIT(INIT), .STRICT_PHASE(0), .CNT_W(CNT_W))
        u_dut3 (.main_clk(main_clk), .main_rst(main_rst), .bus(if3.slave));

    task automatic drive(input logic c1, input logic c2, input logic [7:0] s, input logic [7:0] r);
        if0.c1 = c1; if0.c2 = c2; if0.s = s; if0.r = r;
        if1.c1 = c1; if1.c2 = c2; if1.s = s; if1.r = r;
        if2.c1 = c1; if2.c2 = c2; if2.s = s; if2.r = r;
        if3.c1 = c1; if3.c2 = c2; if3.s = s; if3.r = r;
    endtask

    // Apply one cycle of inputs and sample 1 time unit after the active edge.
    task automatic step(input logic c1, input logic c2, input logic [7:0] s, input logic [7:0] r);
        drive(c1, c2, s, r);
        @(posedge main_clk);
        #1;
        $display("[TB] step c1=%0b c2=%0b s=%h r=%h -> q0=%h q1=%h q2=%h q3=%h cnt0=%0d",
                 c1, c2, s, r, if0.q, if1.q, if2.q, if3.q, if0.cyc_cnt);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        main_rst = 1'b1;
        repeat (2) @(posedge main_clk);
        #1;
        main_rst = 1'b0;
        chk("rst_q0",   16'(if0.q), 16'h00A5);
        chk("rst_q2",   16'(if2.q), 16'h00A5);
        chk("rst_cnt0", 16'(if0.cyc_cnt), 16'h0000);
        chk("rst_pe0",  16'(if0.phase_err), 16'h0000);
        chk("rst_ovl0", 16'(if0.ovl_err), 16'h0000);

        // c1 straight after reset: strict bank flags it, legacy bank does not.
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("strict_q0",   16'(if0.q), 16'h00A5);
        chk("strict_pe0",  16'(if0.phase_err), 16'h0001);
        chk("strict_cnt0", 16'(if0.cyc_cnt), 16'h0000);
        chk("legacy_pe3",  16'(if3.phase_err), 16'h0000);
        chk("legacy_q3",   16'(if3.q), 16'h00A5);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        chk("pe_pulse_end0", 16'(if0.phase_err), 16'h0000);

        // Load 0F in every mode: sample must not reach q before c1.
        step(1'b0, 1'b1, 8'h0F, 8'hF0);
        chk("latency_q0", 16'(if0.q), 16'h00A5);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("load_q0",   16'(if0.q), 16'h000F);
        chk("load_q1",   16'(if1.q), 16'h000F);
        chk("load_q2",   16'(if2.q), 16'h000F);
        chk("load_cnt0", 16'(if0.cyc_cnt), 16'h0001);

        // s=r=FF from q=0F: reset-dominant, set-dominant, toggle.
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("sr_mode0", 16'(if0.q), 16'h0000);
        chk("sr_mode1", 16'(if1.q), 16'h00FF);
        chk("sr_mode2", 16'(if2.q), 16'h00F0);
        chk("sr_mode0_legacy", 16'(if3.q), 16'h0000);
        chk("sr_cnt0", 16'(if0.cyc_cnt), 16'h0002);

        step(1'b0, 1'b1, 8'h0F, 8'h00);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("set0F_q0", 16'(if0.q), 16'h000F);
        chk("set0F_q1", 16'(if1.q), 16'h00FF);
        chk("set0F_q2", 16'(if2.q), 16'h00FF);
        step(1'b0, 1'b1, 8'h00, 8'h03);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("rst03_q0",  16'(if0.q), 16'h000C);
        chk("rst03_q1",  16'(if1.q), 16'h00FC);
        chk("rst03_q2",  16'(if2.q), 16'h00FC);
        chk("rst03_cnt", 16'(if0.cyc_cnt), 16'h0004);

        // Overlap while armed: q takes old stage2 (FC), stage2 takes nx(0C)=0D.
        step(1'b0, 1'b1, 8'hF0, 8'h00);
        step(1'b1, 1'b1, 8'h01, 8'h00);
        chk("ovl_q0",   16'(if0.q), 16'h00FC);
        chk("ovl_cnt0", 16'(if0.cyc_cnt), 16'h0005);
        chk("ovl_flag", 16'(if0.ovl_err), 16'(EXP_OVL));
        chk("ovl_pe0",  16'(if0.phase_err), 16'h0000);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("ovl_after_q0",   16'(if0.q), 16'h000D);
        chk("ovl_after_cnt0", 16'(if0.cyc_cnt), 16'h0006);
        chk("ovl_sticky",     16'(if0.ovl_err), 16'(EXP_OVL));

        // Counter wraps 15 -> 0 (CNT_W=4) after ten more pairs.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h00, 8'h00);
            step(1'b1, 1'b0, 8'h00, 8'h00);
            if (i == 8) chk("cnt_max", 16'(if0.cyc_cnt), 16'h000F);
        end
        chk("cnt_wrap",  16'(if0.cyc_cnt), 16'h0000);
        chk("hold_q0",   16'(if0.q), 16'h000D);

        // Reset between c2 and c1 discards the pending sample.
        step(1'b0, 1'b1, 8'hFF, 8'h00);
        main_rst = 1'b1;
        step(1'b0, 1'b0, 8'h00, 8'h00);
        main_rst = 1'b0;
        chk("midrst_q0",   16'(if0.q), 16'h00A5);
        chk("midrst_ovl0", 16'(if0.ovl_err), 16'h0000);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("midrst_c1_q0",   16'(if0.q), 16'h00A5);
        chk("midrst_c1_pe0",  16'(if0.phase_err), 16'h0001);
        chk("midrst_c1_cnt0", 16'(if0.cyc_cnt), 16'h0000);
        chk("midrst_c1_q3",   16'(if3.q), 16'h00A5);
        chk("midrst_c1_cnt3", 16'(if3.cyc_cnt), 16'h0000);
        chk("midrst_c1_pe3",  16'(if3.phase_err), 16'h0000);

        // Idle cycles hold everything.
        step(1'b0, 1'b0, 8'hFF, 8'hFF);
        step(1'b0, 1'b0, 8'hFF, 8'hFF);
        chk("idle_q1",   16'(if1.q), 16'h00A5);
        chk("idle_pe0",  16'(if0.phase_err), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
